// File: rtl/fir_serial_rx.sv
// fir_serial_rx
//   Receives the FIR filter's LSB-first serial output, reassembles DATA_WIDTH-bit
//   signed samples and buffers them in a first-word-fall-through FIFO. The buffered
//   words are presented on a parallel valid/ready port.
//
// Ports
//   i_clk, i_rst          clock (rising edge), asynchronous active-high reset
//   i_en                  enable; gates only the start of a new serial word
//   i_din, i_din_valid    serial bit and its qualifier (held high for a whole word)
//   o_ready               back-pressure to the filter: serial bits are accepted
//   o_word, o_word_valid  FIFO head word and FIFO non-empty flag
//   i_word_ready          sink pops the head when o_word_valid && i_word_ready
//   o_frame_err           one-cycle pulse when a word is aborted mid-stream
//
// Optional build macro FIR_SERIAL_RX_STATS_EN adds:
//   o_word_count          committed-word counter (16 bits, wraps)
//   o_err_count           frame-error counter (8 bits, saturates at 8'hFF)

module fir_serial_rx #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_din,
  input  logic                  i_din_valid,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_word,
  output logic                  o_word_valid,
  input  logic                  i_word_ready,
`ifdef FIR_SERIAL_RX_STATS_EN
  output logic                  o_frame_err,
  output logic [15:0]           o_word_count,
  output logic [7:0]            o_err_count
`else
  output logic                  o_frame_err
`endif
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic signed [DATA_WIDTH-1:0] sr;
  logic                    ready_nxt;
  logic                    accept;
  logic                    abort;
  logic                    push;
  logic                    pop;
  logic                    full;

  logic signed [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [LVL_W-1:0]        level;
  logic [DATA_WIDTH-1:0]   last_word;

  assign full         = (level == LVL_W'(FIFO_DEPTH));
  assign pop          = i_word_ready && (level != '0);
  assign o_word_valid = (level != '0);
  // When empty, show the most recently popped word rather than a stale slot.
  assign o_word       = (level != '0) ? mem[rd_ptr] : last_word;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    abort     = 1'b0;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (i_din_valid && o_ready) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (!i_din_valid) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else begin
          accept = 1'b1;
          if (cnt == LAST_BIT) state_nxt = COMMIT;
        end
      end
      COMMIT: begin
        push      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Re-arm only from a settled IDLE cycle, so every word is followed by
    // one COMMIT and one IDLE cycle before the next first bit can land.
    ready_nxt = (state_nxt == SHIFT) ||
                ((state == IDLE) && (state_nxt == IDLE) && i_en && !full);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      o_ready     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      o_ready     <= ready_nxt;
      o_frame_err <= abort;
      if (state_nxt == SHIFT) begin
        if (accept) cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

  // LSB arrives first: shifting right leaves bit 0 at position 0 after a full word.
  always_ff @(posedge i_clk) begin
    if (accept) sr <= {i_din, sr[DATA_WIDTH-1:1]};
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= sr;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      last_word <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_W'(1);
        last_word <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

`ifdef FIR_SERIAL_RX_STATS_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_word_count <= '0;
      o_err_count  <= '0;
    end else begin
      if (state == COMMIT) o_word_count <= o_word_count + 16'd1;
      if (o_frame_err && (o_err_count != 8'hFF)) o_err_count <= o_err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fir_serial_rx.sv
// tb_fir_serial_rx
//   Directed bench for fir_serial_rx (DATA_WIDTH=24, FIFO_DEPTH=4): a table of
//   single-word transfers followed by hand-written back-pressure, abort, reset,
//   simultaneous push/pop and (optionally) statistics sequences.

`timescale 1ns/1ps

module tb_fir_serial_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        din;
  logic        din_valid;
  logic        ready;
  logic [23:0] word;
  logic        word_valid;
  logic        word_ready;
  logic        frame_err;
`ifdef FIR_SERIAL_RX_STATS_EN
  logic [15:0] word_count;
  logic [7:0]  err_count;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fir_serial_rx #(.DATA_WIDTH(24), .FIFO_DEPTH(4)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_en         (en),
    .i_din        (din),
    .i_din_valid  (din_valid),
    .o_ready      (ready),
    .o_word       (word),
    .o_word_valid (word_valid),
    .i_word_ready (word_ready),
`ifdef FIR_SERIAL_RX_STATS_EN
    .o_frame_err  (frame_err),
    .o_word_count (word_count),
    .o_err_count  (err_count)
`else
    .o_frame_err  (frame_err)
`endif
  );

  typedef struct {
    logic [23:0] din_word;
    logic [23:0] exp_word;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!ready && n < 60) begin
      tick();
      n++;
    end
    check(name, {31'd0, ready}, 32'd1);
  endtask

  // Sends the low n bits of w LSB-first, then drops din_valid.
  task automatic send_bits(input logic [23:0] w, input int n);
    wait_ready("ready_before_word");
    for (int i = 0; i < n; i++) begin
      din       = w[i];
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    din       = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!word_valid && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic pop();
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
  endtask

  task automatic abort_word();
    send_bits(24'h000001, 1);
    tick();
  endtask

  initial begin
    vecs[0] = '{24'hA5C3F1, 24'hA5C3F1};
    vecs[1] = '{24'h800000, 24'h800000};
    vecs[2] = '{24'h7FFFFF, 24'h7FFFFF};
    vecs[3] = '{24'hFFFFFF, 24'hFFFFFF};
    vecs[4] = '{24'h000000, 24'h000000};
    vecs[5] = '{24'h123456, 24'h123456};

    rst = 1'b1; en = 1'b0; din = 1'b0; din_valid = 1'b0; word_ready = 1'b0;
    tick(); tick();
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_word", {8'd0, word}, 32'd0);
    check("rst_valid", {31'd0, word_valid}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b0;
    en  = 1'b1;
    tick(); tick();
    check("ready_after_rst", {31'd0, ready}, 32'd1);

    // Single-word transfers from the table.
    for (int v = 0; v < 6; v++) begin
      send_bits(vecs[v].din_word, 24);
      check("valid_after_last_bit", {31'd0, word_valid}, 32'd0);
      wait_valid(2);
      check("valid_latency", {31'd0, word_valid}, 32'd1);
      check("vec_word", {8'd0, word}, {8'd0, vecs[v].exp_word});
      pop();
      check("vec_empty_after_pop", {31'd0, word_valid}, 32'd0);
      check("vec_word_hold", {8'd0, word}, {8'd0, vecs[v].exp_word});
    end

    // Back-pressure: fill the FIFO, o_ready must stay low until a pop.
    for (int k = 1; k <= 4; k++) send_bits(24'(k), 24);
    for (int k = 0; k < 5; k++) tick();
    check("full_ready_low", {31'd0, ready}, 32'd0);
    check("full_head", {8'd0, word}, 32'd1);
    pop();
    check("full_head_after_pop", {8'd0, word}, 32'd2);
    begin
      int n = 0;
      while (!ready && n < 3) begin
        tick();
        n++;
      end
    end
    check("ready_after_pop", {31'd0, ready}, 32'd1);
    send_bits(24'h000005, 24);
    tick(); tick();
    for (int k = 2; k <= 5; k++) begin
      check("pop_order", {8'd0, word}, k);
      pop();
    end
    check("fifo_drained", {31'd0, word_valid}, 32'd0);

    // Abort after 10 bits: one error pulse, nothing pushed.
    send_bits(24'hFFFFFF, 10);
    tick();
    check("abort_pulse", {31'd0, frame_err}, 32'd1);
    tick();
    check("abort_pulse_end", {31'd0, frame_err}, 32'd0);
    check("abort_no_push", {31'd0, word_valid}, 32'd0);
    send_bits(24'h800000, 24);
    wait_valid(2);
    check("post_abort_word", {8'd0, word}, 32'h800000);
    pop();

    // Asynchronous reset mid-word with a word already buffered.
    send_bits(24'h0ABCDE, 24);
    tick(); tick();
    check("pre_rst_valid", {31'd0, word_valid}, 32'd1);
    send_bits(24'h123456, 12);
    #2 rst = 1'b1;
    #1;
    check("async_rst_ready", {31'd0, ready}, 32'd0);
    check("async_rst_valid", {31'd0, word_valid}, 32'd0);
    check("async_rst_word", {8'd0, word}, 32'd0);
    tick();
    rst = 1'b0;
    send_bits(24'h654321, 24);
    wait_valid(2);
    check("post_rst_word", {8'd0, word}, 32'h654321);
    pop();

    // Pop on the same edge as a COMMIT write.
    send_bits(24'h111111, 24);
    tick(); tick();
    send_bits(24'h222222, 24);
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    check("pushpop_valid", {31'd0, word_valid}, 32'd1);
    check("pushpop_head", {8'd0, word}, 32'h222222);
    tick();
    check("pushpop_level_one", {31'd0, word_valid}, 32'd1);
    pop();
    check("pushpop_drained", {31'd0, word_valid}, 32'd0);

`ifdef FIR_SERIAL_RX_STATS_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("stats_rst_words", {16'd0, word_count}, 32'd0);
    check("stats_rst_errs", {24'd0, err_count}, 32'd0);
    send_bits(24'h000A01, 24);
    abort_word();
    send_bits(24'h000A02, 24);
    abort_word();
    send_bits(24'h000A03, 24);
    tick(); tick();
    check("stats_words", {16'd0, word_count}, 32'd3);
    check("stats_errs", {24'd0, err_count}, 32'd2);
    for (int k = 0; k < 300; k++) abort_word();
    tick();
    check("stats_err_sat", {24'd0, err_count}, 32'hFF);
    check("stats_words_kept", {16'd0, word_count}, 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
